// File: rtl/edid_ddc_slave.sv
// I2C/DDC target that serves an EDID-style 256-byte memory through an external port.
// SCL/SDA are synchronized and glitch-filtered; SDA is only ever pulled low (open drain).
module edid_ddc_slave #(
    parameter logic [6:0] DEV_ADDR   = 7'h50,
    parameter bit         WRITE_EN   = 1'b1,
    parameter int         FILTER_LEN = 3
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       scl_i,
    input  logic       sda_i,
    output logic       sda_oe,
    output logic [7:0] mem_addr,
    input  logic [7:0] mem_rdata,
    output logic       mem_we,
    output logic [7:0] mem_wdata,
    output logic       busy
);

    localparam int CW = $clog2(FILTER_LEN + 1);

    typedef enum logic [3:0] {
        S_IDLE, S_DEVADDR, S_DEVACK, S_OFFSET, S_OFFACK,
        S_WDATA, S_WDACK, S_RDATA, S_RDACK, S_WAITSTOP
    } state_t;

    logic [1:0] pad_in;
    logic [1:0] filt;
    assign pad_in = {scl_i, sda_i};

    // A filtered level only flips after FILTER_LEN consecutive disagreeing samples.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_cond
            logic [1:0]    sync_reg;
            logic [CW-1:0] cnt_reg;
            logic          lvl_reg;
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    sync_reg <= 2'b11;
                    cnt_reg  <= '0;
                    lvl_reg  <= 1'b1;
                end else begin
                    sync_reg <= {sync_reg[0], pad_in[gi]};
                    if (sync_reg[1] == lvl_reg) begin
                        cnt_reg <= '0;
                    end else if (cnt_reg == CW'(FILTER_LEN - 1)) begin
                        lvl_reg <= sync_reg[1];
                        cnt_reg <= '0;
                    end else begin
                        cnt_reg <= cnt_reg + 1'b1;
                    end
                end
            end
            assign filt[gi] = lvl_reg;
        end
    endgenerate

    logic scl, sda, scl_prev_reg, sda_prev_reg;
    logic scl_rise, scl_fall, start_det, stop_det;
    assign scl       = filt[1];
    assign sda       = filt[0];
    assign scl_rise  = scl & ~scl_prev_reg;
    assign scl_fall  = ~scl & scl_prev_reg;
    assign start_det = scl & scl_prev_reg & sda_prev_reg & ~sda;
    assign stop_det  = scl & scl_prev_reg & ~sda_prev_reg & sda;

    state_t     state_reg;
    logic [3:0] bit_cnt_reg;
    logic [7:0] shift_reg;
    logic [7:0] offset_reg;

    assign mem_addr = offset_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scl_prev_reg <= 1'b1;
            sda_prev_reg <= 1'b1;
            state_reg    <= S_IDLE;
            bit_cnt_reg  <= 4'd0;
            shift_reg    <= 8'h00;
            offset_reg   <= 8'h00;
            sda_oe       <= 1'b0;
            mem_we       <= 1'b0;
            mem_wdata    <= 8'h00;
            busy         <= 1'b0;
        end else begin
            scl_prev_reg <= scl;
            sda_prev_reg <= sda;
            mem_we       <= 1'b0;
            // The offset advances the cycle after the strobe so mem_addr is stable during it.
            if (mem_we) offset_reg <= offset_reg + 8'd1;

            if (start_det) begin
                state_reg   <= S_DEVADDR;
                bit_cnt_reg <= 4'd0;
                sda_oe      <= 1'b0;
            end else if (stop_det) begin
                state_reg <= S_IDLE;
                sda_oe    <= 1'b0;
                busy      <= 1'b0;
            end else begin
                case (state_reg)
                    S_IDLE, S_WAITSTOP: ;
                    S_DEVADDR, S_OFFSET, S_WDATA: begin
                        if (scl_rise && bit_cnt_reg != 4'd8) begin
                            shift_reg   <= {shift_reg[6:0], sda};
                            bit_cnt_reg <= bit_cnt_reg + 4'd1;
                            if (state_reg == S_WDATA && bit_cnt_reg == 4'd7 && WRITE_EN) begin
                                mem_we    <= 1'b1;
                                mem_wdata <= {shift_reg[6:0], sda};
                            end
                        end
                        if (scl_fall && bit_cnt_reg == 4'd8) begin
                            if (state_reg == S_DEVADDR) begin
                                if (shift_reg[7:1] == DEV_ADDR && shift_reg[7:1] != 7'h00) begin
                                    sda_oe    <= 1'b1;
                                    busy      <= 1'b1;
                                    state_reg <= S_DEVACK;
                                end else begin
                                    busy      <= 1'b0;
                                    state_reg <= S_WAITSTOP;
                                end
                            end else if (state_reg == S_OFFSET) begin
                                offset_reg <= shift_reg;
                                sda_oe     <= 1'b1;
                                state_reg  <= S_OFFACK;
                            end else begin
                                sda_oe    <= WRITE_EN;
                                state_reg <= S_WDACK;
                            end
                        end
                    end
                    S_DEVACK: begin
                        if (scl_fall) begin
                            bit_cnt_reg <= 4'd0;
                            if (shift_reg[0]) begin
                                shift_reg  <= mem_rdata;
                                sda_oe     <= ~mem_rdata[7];
                                offset_reg <= offset_reg + 8'd1;
                                state_reg  <= S_RDATA;
                            end else begin
                                sda_oe    <= 1'b0;
                                state_reg <= S_OFFSET;
                            end
                        end
                    end
                    S_OFFACK, S_WDACK: begin
                        if (scl_fall) begin
                            sda_oe      <= 1'b0;
                            bit_cnt_reg <= 4'd0;
                            state_reg   <= S_WDATA;
                        end
                    end
                    S_RDATA: begin
                        // The MSB went out at the byte-start fall; seven more bits, then release.
                        if (scl_fall) begin
                            if (bit_cnt_reg == 4'd7) begin
                                sda_oe    <= 1'b0;
                                state_reg <= S_RDACK;
                            end else begin
                                sda_oe      <= ~shift_reg[6];
                                shift_reg   <= {shift_reg[6:0], 1'b0};
                                bit_cnt_reg <= bit_cnt_reg + 4'd1;
                            end
                        end
                    end
                    S_RDACK: begin
                        if (scl_rise && sda) begin
                            busy      <= 1'b0;
                            state_reg <= S_WAITSTOP;
                        end else if (scl_fall) begin
                            shift_reg   <= mem_rdata;
                            sda_oe      <= ~mem_rdata[7];
                            offset_reg  <= offset_reg + 8'd1;
                            bit_cnt_reg <= 4'd0;
                            state_reg   <= S_RDATA;
                        end
                    end
                    default: state_reg <= S_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_edid_ddc_slave.sv
// Bench: bit-banged I2C master against a read/write target (0x50) and a read-only target (0x51)
// sharing one bus; write strobes and read bytes are checked against a scoreboard.
module tb_edid_ddc_slave;

    localparam int Q = 10;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n, scl, sda_m, sda_line;
    logic       oe0, oe1, we0, we1, busy0, busy1;
    logic [7:0] addr0, addr1, wdata0, wdata1, rdata0, rdata1;

    assign sda_line = sda_m & ~oe0 & ~oe1;

    edid_ddc_slave #(.DEV_ADDR(7'h50), .WRITE_EN(1'b1), .FILTER_LEN(3)) u_dut (
        .clk(clk), .rst_n(rst_n), .scl_i(scl), .sda_i(sda_line), .sda_oe(oe0),
        .mem_addr(addr0), .mem_rdata(rdata0), .mem_we(we0), .mem_wdata(wdata0), .busy(busy0));

    edid_ddc_slave #(.DEV_ADDR(7'h51), .WRITE_EN(1'b0), .FILTER_LEN(3)) u_ro (
        .clk(clk), .rst_n(rst_n), .scl_i(scl), .sda_i(sda_line), .sda_oe(oe1),
        .mem_addr(addr1), .mem_rdata(rdata1), .mem_we(we1), .mem_wdata(wdata1), .busy(busy1));

    logic [7:0] mem [256];
    logic [7:0] ref_mem [256];
    logic       init_done = 1'b0;

    always @(posedge clk) begin
        if (!init_done) begin
            for (int i = 0; i < 256; i++) mem[i] <= 8'(i) ^ 8'hFF;
            init_done <= 1'b1;
        end else if (we0) begin
            mem[addr0] <= wdata0;
        end
        rdata0 <= mem[addr0];
        rdata1 <= mem[addr1];
    end

    logic [15:0] exp_wr [$];
    logic [7:0]  exp_rd [$];
    int n_cmp = 0, n_err = 0;
    int oe_cnt = 0, busy_cnt = 0, we_cnt = 0;
    int snap_oe, snap_busy, snap_we;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            if (oe0 | oe1) oe_cnt <= oe_cnt + 1;
            if (busy0 | busy1) busy_cnt <= busy_cnt + 1;
            if (we0) begin
                we_cnt <= we_cnt + 1;
                if (exp_wr.size() > 0) chk("we_addr_data", {addr0, wdata0}, exp_wr.pop_front());
                else chk("we_unexpected", we0, 1'b0);
            end
            if (we1) chk("ro_we", we1, 1'b0);
        end
    end

    task automatic wait_clks(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic i2c_start;
        sda_m = 1'b1; wait_clks(Q);
        scl = 1'b1;   wait_clks(Q);
        sda_m = 1'b0; wait_clks(Q);
        scl = 1'b0;   wait_clks(Q);
    endtask

    task automatic i2c_stop;
        sda_m = 1'b0; wait_clks(Q);
        scl = 1'b1;   wait_clks(Q);
        sda_m = 1'b1; wait_clks(2 * Q);
    endtask

    task automatic bit_xfer(input logic b, output logic s);
        sda_m = b;  wait_clks(Q);
        scl = 1'b1; wait_clks(Q);
        s = sda_line; wait_clks(Q);
        scl = 1'b0; wait_clks(Q);
    endtask

    task automatic write_byte(input logic [7:0] d, output logic ack);
        logic s;
        for (int i = 7; i >= 0; i--) bit_xfer(d[i], s);
        bit_xfer(1'b1, s);
        ack = ~s;
    endtask

    task automatic read_byte(input logic ack, output logic [7:0] d);
        logic s;
        d = 8'h00;
        for (int i = 0; i < 8; i++) begin
            bit_xfer(1'b1, s);
            d = {d[6:0], s};
        end
        bit_xfer(~ack, s);
    endtask

    task automatic write_seq(input logic [7:0] dev, input logic [7:0] off, input int n,
                             input logic [7:0] d0, input logic [7:0] d1, input logic exp_ack);
        logic       ack;
        logic [7:0] d;
        i2c_start;
        write_byte(dev, ack);  chk("wr_dev_ack", ack, 1'b1);
        write_byte(off, ack);  chk("wr_off_ack", ack, 1'b1);
        chk("busy_mid", (dev == 8'hA0) ? busy0 : busy1, 1'b1);
        for (int i = 0; i < n; i++) begin
            d = (i == 0) ? d0 : d1;
            if (exp_ack) begin
                exp_wr.push_back({off + 8'(i), d});
                ref_mem[off + 8'(i)] = d;
            end
            write_byte(d, ack);
            chk("wr_data_ack", ack, exp_ack);
        end
        i2c_stop;
        chk("wr_oe_idle", oe0 | oe1, 1'b0);
        chk("wr_busy_idle", busy0 | busy1, 1'b0);
        $display("txn write dev=%02h off=%02h n=%0d", dev, off, n);
    endtask

    task automatic read_seq(input logic [7:0] dev, input logic [7:0] off, input int n);
        logic       ack;
        logic [7:0] d;
        i2c_start;
        write_byte(dev, ack);          chk("rd_dev_ack", ack, 1'b1);
        write_byte(off, ack);          chk("rd_off_ack", ack, 1'b1);
        i2c_start;
        write_byte(dev | 8'h01, ack);  chk("rd_devr_ack", ack, 1'b1);
        for (int i = 0; i < n; i++) exp_rd.push_back(ref_mem[off + 8'(i)]);
        for (int i = 0; i < n; i++) begin
            read_byte(i != n - 1, d);
            chk("rd_data", d, exp_rd.pop_front());
        end
        i2c_stop;
        chk("rd_oe_idle", oe0 | oe1, 1'b0);
        chk("rd_busy_idle", busy0 | busy1, 1'b0);
        $display("txn read dev=%02h off=%02h n=%0d", dev, off, n);
    endtask

    initial begin
        logic       ack, s;
        logic [7:0] d;
        for (int i = 0; i < 256; i++) ref_mem[i] = 8'(i) ^ 8'hFF;
        rst_n = 1'b0; scl = 1'b1; sda_m = 1'b1;
        wait_clks(5);
        rst_n = 1'b1;
        wait_clks(5);
        chk("rst_oe", {oe1, oe0}, 2'b00);
        chk("rst_we", {we1, we0}, 2'b00);
        chk("rst_addr", {addr1, addr0}, 16'h0000);
        chk("rst_wdata", wdata0, 8'h00);
        chk("rst_busy", {busy1, busy0}, 2'b00);
        $display("txn reset");

        snap_we = we_cnt;
        write_seq(8'hA0, 8'h10, 1, 8'h5A, 8'h00, 1'b1);
        chk("wr_single_count", we_cnt - snap_we, 1);

        read_seq(8'hA0, 8'h7E, 3);
        chk("rd_addr_end", addr0, 8'h81);

        read_seq(8'hA0, 8'hFE, 4);
        chk("wrap_addr_end", addr0, 8'h02);

        snap_we = we_cnt;
        write_seq(8'hA0, 8'hFF, 2, 8'hC3, 8'h3C, 1'b1);
        chk("wrap_wr_count", we_cnt - snap_we, 2);

        // Address that matches neither target
        snap_oe = oe_cnt; snap_busy = busy_cnt; snap_we = we_cnt;
        i2c_start;
        write_byte(8'hA4, ack); chk("mis_dev_ack", ack, 1'b0);
        write_byte(8'h00, ack); chk("mis_byte_ack", ack, 1'b0);
        i2c_stop;
        chk("mis_oe_cycles", oe_cnt - snap_oe, 0);
        chk("mis_busy_cycles", busy_cnt - snap_busy, 0);
        chk("mis_we", we_cnt - snap_we, 0);
        $display("txn mismatch dev=a4");

        // START in the 5th data bit: no strobe, and the target re-enters address decode
        snap_we = we_cnt;
        d = 8'hE7;
        i2c_start;
        write_byte(8'hA0, ack); chk("abort_dev_ack", ack, 1'b1);
        write_byte(8'h40, ack); chk("abort_off_ack", ack, 1'b1);
        for (int i = 7; i >= 4; i--) bit_xfer(d[i], s);
        i2c_start;
        write_byte(8'hA1, ack); chk("abort_rdev_ack", ack, 1'b1);
        exp_rd.push_back(ref_mem[8'h40]);
        read_byte(1'b0, d);
        chk("abort_rd_data", d, exp_rd.pop_front());
        i2c_stop;
        chk("abort_we", we_cnt - snap_we, 0);
        $display("txn abort off=40");

        // 2-clk SCL glitch inside a data byte must not add a bit
        snap_we = we_cnt;
        d = 8'h96;
        i2c_start;
        write_byte(8'hA0, ack); chk("gl_dev_ack", ack, 1'b1);
        write_byte(8'h30, ack); chk("gl_off_ack", ack, 1'b1);
        exp_wr.push_back({8'h30, d});
        ref_mem[8'h30] = d;
        for (int i = 7; i >= 4; i--) bit_xfer(d[i], s);
        scl = 1'b1; wait_clks(2);
        scl = 1'b0; wait_clks(Q);
        for (int i = 3; i >= 0; i--) bit_xfer(d[i], s);
        bit_xfer(1'b1, s);
        chk("gl_data_ack", s, 1'b0);
        i2c_stop;
        chk("gl_we_count", we_cnt - snap_we, 1);
        $display("txn glitch off=30");

        write_seq(8'hA2, 8'h20, 1, 8'h33, 8'h00, 1'b0);
        read_seq(8'hA2, 8'h20, 1);

        // Reset while the address ACK is being driven
        i2c_start;
        d = 8'hA0;
        for (int i = 7; i >= 0; i--) bit_xfer(d[i], s);
        chk("ack_before_rst", oe0, 1'b1);
        #2 rst_n = 1'b0;
        #1 chk("ack_after_rst", oe0, 1'b0);
        sda_m = 1'b1; scl = 1'b1;
        wait_clks(5);
        rst_n = 1'b1;
        wait_clks(10);
        chk("post_rst_addr", addr0, 8'h00);
        chk("post_rst_busy", busy0, 1'b0);
        $display("txn reset_mid_ack");

        chk("wr_queue_empty", exp_wr.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/edid_ddc_slave.md
# edid_ddc_slave

I2C/DDC responder that presents an EDID-style byte memory to an external HDMI source on the HDMI-input DDC bus. It is the target side of the same I2C protocol our `i2c_config` master drives. It decodes START/STOP, matches a 7-bit device address, and accepts a word offset. It then serves sequential reads, or accepts writes, against an external 256-byte memory port. It sits in the top level next to the HDMI receiver, with SCL/SDA split into input and open-drain enable at the pad.

## Interface
Parameters:
- `DEV_ADDR`, 7'h50, 7-bit address the block responds to.
- `WRITE_EN`, 1, 1 = data bytes after the offset are written to memory and ACKed; 0 = they are NACKed and not written.
- `FILTER_LEN`, 3, number of consecutive equal synchronized samples required before a filtered SCL/SDA level changes.

Ports:
- `clk` in 1: system clock (100 MHz in the loop design). Single clock domain. Reset is asynchronous and active-low (`rst_n`).
- `rst_n` in 1: asynchronous, active-low reset.
- `scl_i` in 1: SCL pad input, asynchronous.
- `sda_i` in 1: SDA pad input, asynchronous.
- `sda_oe` out 1: 1 = pull SDA low (the pad drives 0); 0 = release SDA.
- `mem_addr` out 8: memory byte address, equal to the current offset.
- `mem_rdata` in 8: memory read data, valid 1 clk after `mem_addr` changes.
- `mem_we` out 1: single-cycle write strobe.
- `mem_wdata` out 8: write data, valid while `mem_we` = 1.
- `busy` out 1: high from address match until STOP, a non-matching START, or a master NACK.

## Operation
- Input conditioning: `scl_i`/`sda_i` pass through a 2-FF synchronizer, then a `FILTER_LEN`-sample glitch filter.
  - Edge detection uses only the filtered levels: `scl_rise`, `scl_fall`, `start`, `stop`.
  - START = SDA falls while SCL is high. STOP = SDA rises while SCL is high.
- Bit timing: SDA is sampled on `scl_rise`. The block changes `sda_oe` only on `scl_fall`, never while SCL is high.
- FSM states: IDLE, DEVADDR, DEVACK, OFFSET, OFFACK, WDATA, WDACK, RDATA, RDACK, WAITSTOP.
  - IDLE: a START moves to DEVADDR with the bit counter cleared.
  - DEVADDR: shift in 8 bits (MSB first).
    - If bits[7:1] == `DEV_ADDR`: go to DEVACK.
    - On mismatch: go to WAITSTOP with no ACK.
  - DEVACK: drive `sda_oe`=1 from the 8th `scl_fall` to the 9th `scl_fall`.
    - R/W=0: go to OFFSET.
    - R/W=1: go to RDATA.
  - OFFSET: shift in 8 bits, load the offset register, then ACK (OFFACK), then go to WDATA.
  - WDATA: shift in 8 bits, then WDACK.
    - If `WRITE_EN`: pulse `mem_we` for 1 clk with `mem_wdata` = byte at `mem_addr` = offset. Drive the ACK. Offset += 1 after the strobe.
    - Else: no ACK and no write.
    - Then return to WDATA.
  - RDATA: on each byte start, latch `mem_rdata` into the shift register and increment the offset. Drive the bits MSB first: `sda_oe` = ~bit, updated at each `scl_fall`. After the 8th `scl_fall` release SDA and go to RDACK.
  - RDACK: sample the master bit on `scl_rise`. 0 = ACK, go to RDATA for the next byte. 1 = NACK, go to WAITSTOP.
  - WAITSTOP: SDA released. Wait for STOP (to IDLE) or START (to DEVADDR).
- Offset is 8 bits and wraps 0xFF → 0x00 for both reads and writes.
- Offset persists across repeated START, so a write-offset / repeated-START / read sequence reads from the written offset. Offset is cleared only by reset.
- START in any state aborts the current byte: release SDA, go to DEVADDR. STOP in any state: release SDA, go to IDLE. Neither generates a write strobe for a partial byte.
- General call (0x00) is not supported and is treated as a mismatch.

## Timing
- Reset values: `sda_oe`=0, `mem_we`=0, `mem_addr`=0x00, `mem_wdata`=0x00, `busy`=0, FSM=IDLE, filters preset to 1.
  - Asserting `rst_n` mid-transfer releases SDA immediately (asynchronously).
- Input-to-detect latency: 2 (sync) + `FILTER_LEN` clk. Pulses shorter than `FILTER_LEN` clk are ignored.
- `sda_oe` changes 1 clk after the filtered `scl_fall`. Data hold is ≥ (3+`FILTER_LEN`) clk after the pad falling edge.
- The first read byte is latched at least 2 clk after `mem_addr` is valid.
- Requirement: SCL low time ≥ 16 clk. 100 kHz and 400 kHz are supported at `clk` ≥ 20 MHz.
- `mem_we` fires at the 8th `scl_rise` + 1 clk, before the ACK is driven.

## Test plan
- Random write: START, 0xA0 (ACK), offset 0x10 (ACK), data 0x5A (ACK), STOP → exactly one `mem_we` with addr 0x10, data 0x5A; `sda_oe` low at the end; `busy`=0.
- Random read: START 0xA0, offset 0x7E, repeated START 0xA1, read 3 bytes (ACK, ACK, NACK), STOP, with memory = addr^0xFF → bytes 0x81, 0x80, 0x7F; `mem_addr` ends at 0x81.
- Wrap-around: offset 0xFE, read 4 bytes → addresses 0xFE, 0xFF, 0x00, 0x01. A write burst at 0xFF writes 0xFF then 0x00.
- Address mismatch: START 0xA4, 0x00, STOP → `sda_oe` never asserted, no `mem_we`, `busy` stays 0.
- Abort and glitch: START during the 5th bit of WDATA → no `mem_we`, re-enters DEVADDR. A 2-clk SCL glitch with `FILTER_LEN`=3 → bit count unchanged.
- `WRITE_EN`=0: write 0x33 after offset 0x20 → data byte NACKed, no `mem_we`. A following read returns memory[0x20]. Reset asserted mid-ACK → `sda_oe` 0 within the same clk.
